// File: rtl/scoreboard_hazard_unit_if.sv
// ID-stage <-> hazard-unit bundle for scoreboard_hazard_unit.
// Handshake: id_valid marks a decoded instruction sitting in ID; the
// instruction is consumed only on a cycle where issue=1 (that is, valid with
// no hazard, no flush and no pipe_hold). While issue=0 the ID stage keeps the
// same instruction and id_* fields stable.
interface scoreboard_hazard_unit_if #(
    parameter int REG_AW = 5,
    parameter int LAT_W  = 3,
    parameter int CNT_W  = 32
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic              id_use_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use_rs2;
    logic [REG_AW-1:0] id_rd;
    logic              id_regWrite;
    logic [LAT_W-1:0]  id_lat;
    logic              pipe_hold;
    logic              flush;
    logic              stall;
    logic              stall_rs1;
    logic              stall_rs2;
    logic              stall_waw;
    logic              issue;
    logic [CNT_W-1:0]  stall_count;

    // ID stage side: presents the instruction, receives the stall decision.
    modport master (
        output id_valid, id_rs1, id_use_rs1, id_rs2, id_use_rs2,
               id_rd, id_regWrite, id_lat, pipe_hold, flush,
        input  stall, stall_rs1, stall_rs2, stall_waw, issue, stall_count
    );

    // Hazard unit side.
    modport slave (
        input  id_valid, id_rs1, id_use_rs1, id_rs2, id_use_rs2,
               id_rd, id_regWrite, id_lat, pipe_hold, flush,
        output stall, stall_rs1, stall_rs2, stall_waw, issue, stall_count
    );
endinterface

// File: rtl/scoreboard_hazard_unit.sv
// Per-register latency scoreboard beside the ID stage. Each register holds the
// number of cycles until its in-flight result becomes forwardable; RAW on
// rs1/rs2 and WAW on rd are decided combinationally from those counts.
module scoreboard_hazard_unit #(
    parameter int NUM_REGS = 32,
    parameter int REG_AW   = 5,
    parameter int LAT_W    = 3,
    parameter int CNT_W    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    scoreboard_hazard_unit_if.slave  bus
);
    // Entry 0 is never written, so it stays zero and x0 never looks busy.
    logic [LAT_W-1:0] cnt [NUM_REGS];
    logic [LAT_W-1:0] eff_lat;
    logic [LAT_W-1:0] lat_m1;
    logic             haz_rs1;
    logic             haz_rs2;
    logic             haz_waw;
    logic             haz_any;
    logic             issue_int;
    logic [CNT_W-1:0] stall_cnt;

    // Hazard detection from the current counts; all outputs are held low in reset.
    always_comb begin
        eff_lat   = (bus.id_lat == '0) ? LAT_W'(1) : bus.id_lat;
        lat_m1    = eff_lat - LAT_W'(1);
        haz_rs1   = !rst && bus.id_valid && bus.id_use_rs1 &&
                    (bus.id_rs1 != '0) && (cnt[bus.id_rs1] != '0);
        haz_rs2   = !rst && bus.id_valid && bus.id_use_rs2 &&
                    (bus.id_rs2 != '0) && (cnt[bus.id_rs2] != '0);
        // An older write finishing after this one would leave a stale rd.
        haz_waw   = !rst && bus.id_valid && bus.id_regWrite &&
                    (bus.id_rd != '0) && (cnt[bus.id_rd] > lat_m1);
        haz_any   = haz_rs1 || haz_rs2 || haz_waw;
        issue_int = !rst && bus.id_valid && !haz_any && !bus.flush && !bus.pipe_hold;
    end

    assign bus.stall_rs1   = haz_rs1;
    assign bus.stall_rs2   = haz_rs2;
    assign bus.stall_waw   = haz_waw;
    assign bus.stall       = haz_any;
    assign bus.issue       = issue_int;
    assign bus.stall_count = stall_cnt;

    // Scoreboard: count down while the pipe moves; a new issue overrides its entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
        end else if (!bus.pipe_hold) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - LAT_W'(1);
                end
            end
            if (issue_int && bus.id_regWrite && (bus.id_rd != '0)) begin
                cnt[bus.id_rd] <= lat_m1;
            end
        end
    end

    // Stall-cycle performance counter, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (haz_any && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Bench for scoreboard_hazard_unit: directed scenarios plus random traffic,
// all checked against a ready-time reference model.
module tb_scoreboard_hazard_unit;
    localparam int REG_AW = 5;
    localparam int LAT_W  = 3;
    localparam int CNT_W  = 8;
    localparam int NREG   = 32;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic clk;
    logic rst;

    scoreboard_hazard_unit_if #(.REG_AW(REG_AW), .LAT_W(LAT_W), .CNT_W(CNT_W)) bus ();

    scoreboard_hazard_unit #(
        .NUM_REGS(NREG), .REG_AW(REG_AW), .LAT_W(LAT_W), .CNT_W(CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    // tick advances once per edge where the pipe moves; a register's result is
    // forwardable once tick reaches ready_at[r].
    longint           tick;
    longint           ready_at [NREG];
    int               exp_count;
    logic [CNT_W-1:0] exp_q [$];
    logic             e_rs1, e_rs2, e_waw, e_stall, e_issue;
    logic             obs_stall, obs_issue;
    int               n_cmp;
    int               n_err;

    function automatic longint remaining(input int r);
        if (r == 0) return 0;
        return (ready_at[r] > tick) ? ready_at[r] - tick : 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_eval();
        int lat;
        lat     = (bus.id_lat == 0) ? 1 : int'(bus.id_lat);
        e_rs1   = !rst && bus.id_valid && bus.id_use_rs1 && remaining(int'(bus.id_rs1)) > 0;
        e_rs2   = !rst && bus.id_valid && bus.id_use_rs2 && remaining(int'(bus.id_rs2)) > 0;
        e_waw   = !rst && bus.id_valid && bus.id_regWrite && bus.id_rd != 0 &&
                  remaining(int'(bus.id_rd)) >= lat;
        e_stall = e_rs1 || e_rs2 || e_waw;
        e_issue = !rst && bus.id_valid && !e_stall && !bus.flush && !bus.pipe_hold;
    endtask

    task automatic model_update();
        int lat;
        lat = (bus.id_lat == 0) ? 1 : int'(bus.id_lat);
        if (rst) begin
            for (int r = 0; r < NREG; r++) ready_at[r] = 0;
            exp_count = 0;
        end else begin
            if (e_stall && exp_count < CMAX) exp_count++;
            if (!bus.pipe_hold) begin
                if (e_issue && bus.id_regWrite && bus.id_rd != 0)
                    ready_at[bus.id_rd] = tick + lat;
                tick++;
            end
        end
        exp_q.push_back(CNT_W'(exp_count));
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_id(input logic v, input int rs1, input logic u1, input int rs2,
                          input logic u2, input int rd, input logic w, input int lat);
        bus.id_valid    = v;
        bus.id_rs1      = REG_AW'(rs1);
        bus.id_use_rs1  = u1;
        bus.id_rs2      = REG_AW'(rs2);
        bus.id_use_rs2  = u2;
        bus.id_rd       = REG_AW'(rd);
        bus.id_regWrite = w;
        bus.id_lat      = LAT_W'(lat);
    endtask

    task automatic idle();
        set_id(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 0);
        bus.pipe_hold = 1'b0;
        bus.flush     = 1'b0;
    endtask

    // One clock: check outputs mid-cycle, then advance the model on the edge.
    task automatic cycle();
        @(negedge clk);
        model_eval();
        obs_stall = bus.stall;
        obs_issue = bus.issue;
        check("stall_rs1", 32'(bus.stall_rs1), 32'(e_rs1));
        check("stall_rs2", 32'(bus.stall_rs2), 32'(e_rs2));
        check("stall_waw", 32'(bus.stall_waw), 32'(e_waw));
        check("stall",     32'(bus.stall),     32'(e_stall));
        check("issue",     32'(bus.issue),     32'(e_issue));
        if (exp_q.size() > 0) check("stall_count", 32'(bus.stall_count), 32'(exp_q.pop_front()));
        @(posedge clk);
        model_update();
        #1;
    endtask

    // Present the current instruction until it issues; returns stall cycles seen.
    // pipe_hold is raised for hold_len cycles starting at cycle hold_start.
    task automatic issue_wait(input string tag, input int hold_start, input int hold_len,
                              output int stalls);
        int k;
        logic done;
        stalls = 0;
        done   = 1'b0;
        for (k = 0; k < 40 && !done; k++) begin
            bus.pipe_hold = (k >= hold_start) && (k < hold_start + hold_len);
            cycle();
            if (obs_stall) stalls++;
            if (obs_issue) done = 1'b1;
        end
        bus.pipe_hold = 1'b0;
        if (!done) check({tag, "_timeout"}, 32'(0), 32'(1));
        idle();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int s;
        int c0;
        n_cmp = 0;
        n_err = 0;
        tick  = 0;
        exp_count = 0;
        for (int r = 0; r < NREG; r++) ready_at[r] = 0;
        rst = 1'b1;
        idle();
        cycle();
        cycle();
        rst = 1'b0;
        check("reset_count", 32'(bus.stall_count), 32'(0));

        // 1: ALU chain, no stall
        set_id(1, 0, 0, 0, 0, 5, 1, 1); issue_wait("alu_p", -1, 0, s);
        check("alu_prod_stalls", 32'(s), 32'(0));
        set_id(1, 5, 1, 0, 0, 11, 1, 1); issue_wait("alu_c", -1, 0, s);
        check("alu_cons_stalls", 32'(s), 32'(0));

        // 2: load-use, one bubble
        c0 = int'(bus.stall_count);
        set_id(1, 0, 0, 0, 0, 6, 1, 2); issue_wait("ld_p", -1, 0, s);
        set_id(1, 1, 1, 6, 1, 14, 1, 1); issue_wait("ld_c", -1, 0, s);
        check("load_use_stalls", 32'(s), 32'(1));
        cycle();
        check("load_use_count", 32'(int'(bus.stall_count) - c0), 32'(1));

        // 3: divider, without and with a pipe_hold window
        set_id(1, 0, 0, 0, 0, 7, 1, 6); issue_wait("div_p", -1, 0, s);
        set_id(1, 7, 1, 0, 0, 15, 1, 1); issue_wait("div_c", -1, 0, s);
        check("div_stalls", 32'(s), 32'(5));
        set_id(1, 0, 0, 0, 0, 7, 1, 6); issue_wait("divh_p", -1, 0, s);
        set_id(1, 7, 1, 0, 0, 15, 1, 1); issue_wait("divh_c", 2, 3, s);
        check("div_hold_stalls", 32'(s), 32'(8));

        // 4: WAW, then L=0 treated as L=1
        set_id(1, 0, 0, 0, 0, 8, 1, 5); issue_wait("waw_p", -1, 0, s);
        set_id(1, 0, 0, 0, 0, 8, 1, 1); issue_wait("waw_c", -1, 0, s);
        check("waw_stalls", 32'(s), 32'(4));
        set_id(1, 8, 1, 0, 0, 12, 1, 0); issue_wait("lat0_p", -1, 0, s);
        check("lat0_prod_stalls", 32'(s), 32'(0));
        set_id(1, 12, 1, 12, 1, 12, 1, 1); issue_wait("lat0_c", -1, 0, s);
        check("lat0_cons_stalls", 32'(s), 32'(0));

        // 5: x0 never tracked; flush blocks issue while counting continues
        set_id(1, 0, 0, 0, 0, 0, 1, 7); issue_wait("x0_p", -1, 0, s);
        set_id(1, 0, 1, 0, 1, 0, 1, 1); issue_wait("x0_c", -1, 0, s);
        check("x0_stalls", 32'(s), 32'(0));
        set_id(1, 0, 0, 0, 0, 9, 1, 3); issue_wait("fl_p", -1, 0, s);
        set_id(1, 9, 1, 0, 0, 16, 1, 1);
        bus.flush = 1'b1;
        cycle();
        check("flush_issue", 32'(obs_issue), 32'(0));
        bus.flush = 1'b0;
        issue_wait("fl_c", -1, 0, s);
        check("flush_after_stalls", 32'(s), 32'(1));

        // 6: reset with a pending write
        set_id(1, 0, 0, 0, 0, 10, 1, 6); issue_wait("rst_p", -1, 0, s);
        set_id(1, 10, 1, 10, 1, 10, 1, 1);
        rst = 1'b1;
        cycle();
        check("rst_stall", 32'(obs_stall), 32'(0));
        check("rst_issue", 32'(obs_issue), 32'(0));
        rst = 1'b0;
        check("rst_count", 32'(bus.stall_count), 32'(0));
        issue_wait("rst_c", -1, 0, s);
        check("post_rst_stalls", 32'(s), 32'(0));

        // Random traffic over a small register window for dense hazards
        for (int i = 0; i < 600; i++) begin
            set_id($urandom_range(3, 0) != 0, $urandom_range(7, 0), 1'($urandom),
                   $urandom_range(7, 0), 1'($urandom), $urandom_range(7, 0),
                   1'($urandom), $urandom_range(7, 0));
            bus.pipe_hold = ($urandom_range(7, 0) == 0);
            bus.flush     = ($urandom_range(9, 0) == 0);
            rst           = ($urandom_range(99, 0) == 0);
            cycle();
        end
        rst = 1'b0;
        idle();

        // Saturation: hold a stalled dependent long enough to pin the counter
        set_id(1, 0, 0, 0, 0, 13, 1, 7); issue_wait("sat_p", -1, 0, s);
        set_id(1, 13, 1, 0, 0, 17, 1, 1);
        bus.pipe_hold = 1'b1;
        for (int i = 0; i < CMAX + 40; i++) cycle();
        check("sat_count", 32'(bus.stall_count), 32'(CMAX));
        idle();
        cycle();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
